blinker_ctrl: RTL and testbench
===============================

// Module: blinker_ctrl
// PURPOSE
//  Front-panel controller for the LED blinker. Debounces four raw active-low push-buttons.
//  Converts them into the blinker's control inputs: a 4-bit speed setting (delay),
//  a single-cycle pause-toggle pulse and a single-cycle blinker reset.
//  Also tracks run/paused state, so delay steps are only accepted while running.
// PARAMETERS
//  DEBOUNCE_CYCLES  50000  consecutive stable cycles before a button change is accepted (>=2)
//  DELAY_MIN        1      lowest delay value (fastest blink); must be >=1
//  DELAY_MAX        15     highest delay value (slowest blink); must be <=15 and >=DELAY_MIN
//  DELAY_INIT       8      delay value after reset/reset-button; DELAY_MIN<=DELAY_INIT<=DELAY_MAX
// PORTS
//  clk          in   1  system clock
//  reset        in   1  synchronous reset, active-high
//  btn_pause_n  in   1  raw pause button, active-low, asynchronous to clk
//  btn_faster_n in   1  raw faster button, active-low, async
//  btn_slower_n in   1  raw slower button, active-low, async
//  btn_reset_n  in   1  raw blinker-reset button, active-low, async
//  delay        out  4  speed setting to the blinker
//  pause        out  1  one-cycle pulse that toggles the blinker's run state
//  blink_reset  out  1  one-cycle reset pulse to the blinker
//  paused       out  1  status: 1 = blinker is currently held
// BEHAVIOUR
//  Reset values (registered, every output): delay=DELAY_INIT, pause=0, blink_reset=1, paused=0.
//   - blink_reset stays 1 for every cycle reset is high and drops the first cycle after.
//   - All debouncers reset to "released"; sync flops reset to 1; FSM state=RUN.
//  Input path, per button, independent:
//   - 2-flop synchronizer.
//   - Counter increments while the sync output differs from the stable value, and clears when equal.
//   - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the stable value flips.
//   - A press event is a registered 1-cycle pulse on stable released->pressed. Releases make no event.
//   - Latency: raw low first sampled at edge N gives the event pulse in cycle N+DEBOUNCE_CYCLES+2.
//   - A glitch shorter than DEBOUNCE_CYCLES cycles makes no event.
//   - A held button makes exactly one event.
//  Event priority in one cycle: reset_evt > pause_evt > (faster/slower).
//   - Lower-priority events in the same cycle are dropped, not queued.
//  FSM, 2 states, RUN and PAUSED:
//   - RUN, pause_evt: pause=1 for the next cycle, go to PAUSED, paused=1.
//   - PAUSED, pause_evt: pause=1 for the next cycle, go to RUN, paused=0.
//   - Any state, reset_evt: blink_reset=1 for the next cycle, delay<=DELAY_INIT, state<=RUN,
//     paused=0, pause=0.
//   - RUN, faster_evt only: delay<=delay-1, saturating at DELAY_MIN.
//   - RUN, slower_evt only: delay<=delay+1, saturating at DELAY_MAX.
//   - RUN, faster_evt and slower_evt together: delay unchanged.
//   - PAUSED: faster/slower events are ignored; delay holds.
//  Output timing:
//   - pause and blink_reset are never high for 2 consecutive cycles because of button events.
//     Events are at least DEBOUNCE_CYCLES apart.
//   - delay arithmetic is 4-bit unsigned and never wraps. Saturation is checked before +/-1.
//  Reset mid-operation:
//   - Reset asserted mid-debounce discards the partial count; no event is emitted.
//   - Reset asserted while pause/blink_reset pulses are in flight cancels them.
//   - A button held through reset release is "newly pressed": one event after the debounce time.
// TESTING  (use DEBOUNCE_CYCLES=4, DELAY_INIT=8, DELAY_MIN=1, DELAY_MAX=15)
//  1. Reset 3 cycles, then idle -> delay=8, paused=0, pause=0.
//     blink_reset=1 during reset and 0 after.
//  2. btn_pause_n low at edge N, held 20 cycles -> pause=1 only in cycle N+6, paused=1 from N+7.
//     A second press -> paused=0.
//  3. btn_faster_n low for 3 cycles (glitch) -> no event, delay stays 8.
//     Nine clean presses -> delay 7,6,...,1, then stays 1.
//  4. Eight clean slower presses from delay=13 -> 14, 15, then stays 15.
//     Then press while PAUSED -> delay stays 15.
//  5. faster and slower pressed on the same edge -> delay unchanged.
//     reset and pause on the same edge -> blink_reset pulse only, no pause pulse,
//     delay=8, paused=0.
//  6. Reset asserted 2 cycles into a pause-button debounce -> no pause pulse.
//     Button still held after reset release -> pause pulse 6 cycles after release.

Source files
------------

// File: rtl/blinker_ctrl.sv
// blinker_ctrl: debounces four active-low buttons (clk, reset; btn_pause_n/faster_n/slower_n/reset_n in) into blinker controls (delay[3:0], pause, blink_reset, paused out)
module blinker_ctrl #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DELAY_MIN = 1,
  parameter int DELAY_MAX = 15,
  parameter int DELAY_INIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_pause_n,
  input  logic       btn_faster_n,
  input  logic       btn_slower_n,
  input  logic       btn_reset_n,
  output logic [3:0] delay,
  output logic       pause,
  output logic       blink_reset,
  output logic       paused
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] DMIN = 4'(DELAY_MIN);
  localparam logic [3:0] DMAX = 4'(DELAY_MAX);
  localparam logic [3:0] DINIT = 4'(DELAY_INIT);
  typedef enum logic {RUN, PAUSED} state_t;
  logic [3:0] raw, sync1, sync2, stable, evt;
  logic [CW-1:0] cnt [4];
  state_t state, state_nx;
  logic [3:0] delay_nx;
  logic pause_nx, blink_reset_nx;
  assign raw = {btn_reset_n, btn_pause_n, btn_slower_n, btn_faster_n};
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
      stable <= '1;
      evt <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      evt <= '0;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == stable[i]) cnt[i] <= '0;
        else if (cnt[i] == CNT_LAST) begin
          cnt[i] <= '0;
          stable[i] <= sync2[i];
          evt[i] <= ~sync2[i];
        end else cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end
  always_comb begin
    state_nx = state;
    delay_nx = delay;
    pause_nx = 1'b0;
    blink_reset_nx = 1'b0;
    if (evt[3]) begin
      blink_reset_nx = 1'b1;
      delay_nx = DINIT;
      state_nx = RUN;
    end else if (evt[2]) begin
      pause_nx = 1'b1;
      state_nx = state == RUN ? PAUSED : RUN;
    end else if (state == RUN && evt[0] != evt[1])
      delay_nx = evt[0] ? (delay > DMIN ? delay - 4'd1 : delay)
                        : (delay < DMAX ? delay + 4'd1 : delay);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      delay <= DINIT;
      pause <= 1'b0;
      blink_reset <= 1'b1;
    end else begin
      state <= state_nx;
      delay <= delay_nx;
      pause <= pause_nx;
      blink_reset <= blink_reset_nx;
    end
  end
  assign paused = state == PAUSED;
endmodule

// File: tb/tb_blinker_ctrl.sv
// tb_blinker_ctrl: randomized button stimulus checked against a sample-window reference model
module tb_blinker_ctrl;
  localparam int D = 4;
  localparam int DMIN = 1;
  localparam int DMAX = 15;
  localparam int DINIT = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_pause_n = 1'b1, btn_faster_n = 1'b1, btn_slower_n = 1'b1, btn_reset_n = 1'b1;
  logic [3:0] delay;
  logic pause, blink_reset, paused;
  int n_cmp = 0;
  int n_bad = 0;
  int m_delay;
  bit m_pause, m_br, m_paused;
  bit [3:0] m_evt, m_stable, btn;
  bit h [4][D+1];
  blinker_ctrl #(.DEBOUNCE_CYCLES(D), .DELAY_MIN(DMIN), .DELAY_MAX(DMAX), .DELAY_INIT(DINIT)) dut (
    .clk(clk), .reset(reset), .btn_pause_n(btn_pause_n), .btn_faster_n(btn_faster_n),
    .btn_slower_n(btn_slower_n), .btn_reset_n(btn_reset_n), .delay(delay), .pause(pause),
    .blink_reset(blink_reset), .paused(paused));
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask
  // Reference: a button's debounced level flips once its last D synchronized samples all disagree with it.
  task automatic model(input bit r, input bit [3:0] b);
    bit [3:0] nevt;
    bit flip;
    if (r) begin
      m_delay = DINIT; m_pause = 0; m_br = 1; m_paused = 0; m_evt = '0; m_stable = '1;
      for (int i = 0; i < 4; i++) for (int k = 0; k <= D; k++) h[i][k] = 1'b1;
      return;
    end
    m_br = m_evt[3];
    m_pause = !m_evt[3] && m_evt[2];
    if (m_evt[3]) begin
      m_delay = DINIT;
      m_paused = 0;
    end else if (m_evt[2]) m_paused = !m_paused;
    else if (!m_paused && m_evt[0] && !m_evt[1]) m_delay = (m_delay - 1 < DMIN) ? DMIN : m_delay - 1;
    else if (!m_paused && m_evt[1] && !m_evt[0]) m_delay = (m_delay + 1 > DMAX) ? DMAX : m_delay + 1;
    nevt = '0;
    for (int i = 0; i < 4; i++) begin
      flip = 1;
      for (int k = 1; k <= D; k++) if (h[i][k] == m_stable[i]) flip = 0;
      if (flip) begin
        m_stable[i] = !m_stable[i];
        nevt[i] = !m_stable[i];
      end
      for (int k = D; k > 0; k--) h[i][k] = h[i][k-1];
      h[i][0] = b[i];
    end
    m_evt = nevt;
  endtask
  task automatic step(input bit r, input bit [3:0] b);
    reset = r;
    {btn_reset_n, btn_pause_n, btn_slower_n, btn_faster_n} = b;
    @(posedge clk);
    model(r, b);
    #1;
    check("delay", int'(delay), m_delay);
    check("pause", int'(pause), int'(m_pause));
    check("blink_reset", int'(blink_reset), int'(m_br));
    check("paused", int'(paused), int'(m_paused));
    @(negedge clk);
  endtask
  // gang=1 toggles all masked buttons together to hit same-edge presses
  task automatic run_phase(input int n, input bit [3:0] mask, input bit gang, input int rst_odds);
    btn = '1;
    step(1'b1, btn);
    step(1'b1, btn);
    for (int i = 0; i < n; i++) begin
      if (gang) begin
        if ($urandom_range(0, 9) == 0) btn = btn ^ mask;
      end else
        for (int k = 0; k < 4; k++)
          if (mask[k] && $urandom_range(0, k == 3 ? 31 : 7) == 0) btn[k] = !btn[k];
      step(rst_odds != 0 && $urandom_range(1, rst_odds) == 1, btn);
    end
  endtask
  initial begin
    @(negedge clk);
    btn = '1;
    for (int i = 0; i < 3; i++) step(1'b1, btn);
    for (int i = 0; i < 5; i++) step(1'b0, btn);
    run_phase(1500, 4'b1111, 1'b0, 150);
    run_phase(500, 4'b0010, 1'b0, 0);
    run_phase(300, 4'b0110, 1'b0, 0);
    run_phase(500, 4'b0001, 1'b0, 0);
    run_phase(400, 4'b0011, 1'b1, 0);
    run_phase(400, 4'b1100, 1'b1, 0);
    run_phase(600, 4'b0100, 1'b0, 40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
